// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit serializer.
// Sends start bit, 5-8 data bits LSB first, optional parity, then 1 or 2 stop bits.
// The frame format and data are captured when the frame is accepted, so later
// register writes cannot disturb a frame that is already on the line.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | line high, waiting for a rising edge on start_tx
// START  | driving the start bit (0)
// DATA   | driving shadow_data[bit_idx], LSB first
// PARITY | driving the parity bit over the used data bits
// STOP   | driving stop bit(s); bit_idx counts the second stop bit
module uart_tx_engine #(
  parameter int DIVISOR = 434,
  parameter int CNT_W   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       start_tx,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic             tx_nxt, busy_nxt, done_nxt;
  logic             start_q, start_pe;
  logic             load_shadow;

  logic [7:0]       shadow_data;
  logic [1:0]       shadow_dbn;
  logic             shadow_stop2;
  logic             shadow_pe;
  logic             shadow_pt;

  logic             bit_end;
  logic [2:0]       last_idx;
  logic [2:0]       idx_inc;
  logic [1:0]       mask_shift;
  logic [7:0]       data_mask;
  logic             parity_bit;

  assign start_pe   = start_tx & ~start_q;
  assign bit_end    = (baud_cnt == CNT_W'(DIVISOR - 1));
  assign last_idx   = 3'd4 + {1'b0, shadow_dbn};
  assign idx_inc    = bit_idx + 3'd1;
  assign mask_shift = 2'd3 - shadow_dbn;
  assign data_mask  = 8'hFF >> mask_shift;
  assign parity_bit = (^(shadow_data & data_mask)) ^ shadow_pt;

  // Edge detector history for start_tx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start_tx;
    end
  end

  // Capture data and frame format on acceptance only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data  <= 8'h00;
      shadow_dbn   <= 2'b00;
      shadow_stop2 <= 1'b0;
      shadow_pe    <= 1'b0;
      shadow_pt    <= 1'b0;
    end else if (load_shadow) begin
      shadow_data  <= tx_data;
      shadow_dbn   <= data_bit_num;
      shadow_stop2 <= stop_bit_num;
      shadow_pe    <= parity_en;
      shadow_pt    <= parity_type;
    end
  end

  // FSM state, baud timer, bit index and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      tx       <= tx_nxt;
      tx_busy  <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

  // Next-state and next-output logic; tx only changes on bit boundaries.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    tx_nxt       = tx;
    busy_nxt     = tx_busy;
    done_nxt     = tx_done;
    load_shadow  = 1'b0;

    if (state != IDLE) begin
      baud_cnt_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);
    end

    case (state)
      IDLE: begin
        if (start_pe) begin
          load_shadow  = 1'b1;
          state_nxt    = START;
          baud_cnt_nxt = '0;
          bit_idx_nxt  = 3'd0;
          tx_nxt       = 1'b0;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          bit_idx_nxt = 3'd0;
          tx_nxt      = shadow_data[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == last_idx) begin
            bit_idx_nxt = 3'd0;
            if (shadow_pe) begin
              state_nxt = PARITY;
              tx_nxt    = parity_bit;
            end else begin
              state_nxt = STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            bit_idx_nxt = idx_inc;
            tx_nxt      = shadow_data[idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt   = STOP;
          bit_idx_nxt = 3'd0;
          tx_nxt      = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (shadow_stop2 && (bit_idx == 3'd0)) begin
            bit_idx_nxt = 3'd1;
          end else begin
            state_nxt   = IDLE;
            bit_idx_nxt = 3'd0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        baud_cnt_nxt = '0;
        bit_idx_nxt  = 3'd0;
        tx_nxt       = 1'b1;
        busy_nxt     = 1'b0;
      end
    endcase
  end

endmodule
